fetch_sequencer: RTL and testbench

Owns the architectural fetch PC and decides, every cycle, which next-PC source wins: sequential increment, a resolved branch/jump redirect from decode, or a hold for a hazard stall or a slow instruction memory. It sits between the decode-stage branch resolution logic and the instruction-memory port. It buffers a redirect that cannot be applied immediately and drives a fetch-valid handshake and a flush pulse to the fetch/decode pipeline register.

---
 rtl/fetch_seq_pkg.sv | 21 ++
 rtl/fetch_redirect_buf.sv | 58 +++++
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared types and constants for the fetch sequencer.
//   fetch_state_e  : sequencer FSM states (BOOT, FETCH, SLOT)
//   PC_INC         : sequential fetch increment
//   PC_ALIGN_MASK  : low address bits forced to zero on redirect targets
//   align_pc()     : applies PC_ALIGN_MASK to a 32-bit address
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SLOT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], pc[1:0] & ~PC_ALIGN_MASK};
  endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// fetch_redirect_buf: one-entry buffer for a redirect target that must wait
// for the delay-slot fetch to complete. Only used when
// FETCH_SEQ_DELAY_SLOT_EN is defined.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   load_i         : capture target_i and mark the entry valid
//   target_i       : aligned redirect target
//   clear_i        : pending target consumed (handshake in SLOT)
//   drop_i         : redirect arrived while one is pending (sets sticky error)
//   pending_o      : entry valid
//   target_o       : buffered target
//   slot_err_o     : sticky double-redirect error
module fetch_redirect_buf
  import fetch_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] target_i,
  input  logic        clear_i,
  input  logic        drop_i,
  output logic        pending_o,
  output logic [31:0] target_o,
  output logic        slot_err_o
);

  logic        pending_q, pending_d;
  logic [31:0] target_q, target_d;
  logic        err_q, err_d;

  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    err_d     = err_q | drop_i;
    if (load_i) begin
      pending_d = 1'b1;
      target_d  = align_pc(target_i);
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      target_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
      err_q     <= err_d;
    end
  end

  assign pending_o  = pending_q;
  assign target_o   = target_q;
  assign slot_err_o = err_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC and selects the next-PC source every
// cycle (sequential +4, decode redirect, or hold for stall / slow memory).
// Optional feature macro: FETCH_SEQ_DELAY_SLOT_EN (MIPS delay-slot redirects
// buffered through fetch_redirect_buf; otherwise redirects flush).
//   w_clk, w_rst_n       : clock, asynchronous active-low reset
//   w_stall              : hazard stall, holds PC and suppresses fetch
//   w_redirect_valid     : taken branch / jump pulse from decode
//   w_redirect_pc_32     : redirect target (low two bits ignored)
//   w_imem_ready         : instruction memory accepts the fetch this cycle
//   w_pc_32              : current fetch address
//   w_fetch_valid        : fetch request valid
//   w_flush              : kill the instruction in the fetch/decode register
//   w_redirect_pending   : buffered redirect waiting (SLOT)
//   w_slot_err           : sticky, redirect arrived while one was pending
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_stall,
  input  logic        w_redirect_valid,
  input  logic [31:0] w_redirect_pc_32,
  input  logic        w_imem_ready,
  output logic [31:0] w_pc_32,
  output logic        w_fetch_valid,
  output logic        w_flush,
  output logic        w_redirect_pending,
  output logic        w_slot_err
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic [3:0]   boot_cnt_q, boot_cnt_d;
  logic [31:0]  pc_q, pc_d;
  logic         flush_q, flush_d;
  logic         handshake;
  logic [31:0]  redirect_tgt;

`ifdef FETCH_SEQ_DELAY_SLOT_EN
  logic        buf_load, buf_clear, buf_drop;
  logic        buf_pending;
  logic [31:0] buf_target;
`endif

  assign w_fetch_valid = (state_q != ST_BOOT) & ~w_stall;
  assign handshake     = w_fetch_valid & w_imem_ready;
  assign redirect_tgt  = align_pc(w_redirect_pc_32);

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
`ifdef FETCH_SEQ_DELAY_SLOT_EN
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    buf_drop   = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_redirect_valid) begin
`ifdef FETCH_SEQ_DELAY_SLOT_EN
          // The in-flight address is the delay slot: redirect only once it
          // has been accepted, otherwise park the target until it is.
          if (handshake) begin
            pc_d = redirect_tgt;
          end else begin
            buf_load = 1'b1;
            state_d  = ST_SLOT;
          end
`else
          pc_d    = redirect_tgt;
          flush_d = 1'b1;
`endif
        end else if (handshake) begin
          pc_d = pc_q + PC_INC;
        end
      end
`ifdef FETCH_SEQ_DELAY_SLOT_EN
      ST_SLOT: begin
        buf_drop = w_redirect_valid;
        if (handshake) begin
          pc_d      = buf_target;
          buf_clear = 1'b1;
          state_d   = ST_FETCH;
        end
      end
`endif
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
    end
  end

  assign w_pc_32 = pc_q;
  assign w_flush = flush_q;

`ifdef FETCH_SEQ_DELAY_SLOT_EN
  fetch_redirect_buf u_redirect_buf (
    .clk_i      (w_clk),
    .rst_ni     (w_rst_n),
    .load_i     (buf_load),
    .target_i   (redirect_tgt),
    .clear_i    (buf_clear),
    .drop_i     (buf_drop),
    .pending_o  (buf_pending),
    .target_o   (buf_target),
    .slot_err_o (w_slot_err)
  );

  assign w_redirect_pending = buf_pending;
`else
  assign w_redirect_pending = 1'b0;
  assign w_slot_err         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer. Each driven cycle
// pushes the expected post-edge outputs {pc, fetch_valid, flush, pending,
// slot_err}; scenario tasks pop and compare after the clock edge. Builds in
// either configuration of FETCH_SEQ_DELAY_SLOT_EN.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          BOOT   = 2;
`ifdef FETCH_SEQ_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic        rdy = 1'b0;
  logic [31:0] pc;
  logic        fv, flush, pend, err;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        flush;
    logic        pend;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  exp_t obs;
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model state
  int          m_state;
  int          m_cnt;
  logic [31:0] m_pc, m_ptgt;
  logic        m_flush, m_pend, m_err;

  fetch_sequencer #(
    .RESET_PC   (RST_PC),
    .BOOT_CYCLES(BOOT)
  ) dut (
    .w_clk             (clk),
    .w_rst_n           (rst_n),
    .w_stall           (stall),
    .w_redirect_valid  (rv),
    .w_redirect_pc_32  (rpc),
    .w_imem_ready      (rdy),
    .w_pc_32           (pc),
    .w_fetch_valid     (fv),
    .w_flush           (flush),
    .w_redirect_pending(pend),
    .w_slot_err        (err)
  );

  always #5 clk = ~clk;

  assign obs = {pc, fv, flush, pend, err};

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_pc = RST_PC; m_ptgt = '0;
    m_flush = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    sbq.delete();
  endtask

  // Drive one cycle of stimulus, push the expected outputs after the edge.
  task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic m);
    exp_t        x;
    logic        hs;
    logic [31:0] tgt;
    @(negedge clk);
    stall = s; rv = r; rpc = t; rdy = m;
    hs  = (m_state != 0) && !s && m;
    tgt = {t[31:2], 2'b00};
    m_flush = 1'b0;
    case (m_state)
      0: begin
        if (m_cnt == BOOT - 1) m_state = 1;
        m_cnt++;
      end
      1: begin
        if (r) begin
          if (DS) begin
            if (hs) m_pc = tgt;
            else begin m_ptgt = tgt; m_pend = 1'b1; m_state = 2; end
          end else begin
            m_pc = tgt; m_flush = 1'b1;
          end
        end else if (hs) begin
          m_pc = m_pc + 32'd4;
        end
      end
      default: begin
        if (r) m_err = 1'b1;
        if (hs) begin m_pc = m_ptgt; m_pend = 1'b0; m_state = 1; end
      end
    endcase
    x.pc = m_pc; x.fv = (m_state != 0) && !s; x.flush = m_flush;
    x.pend = m_pend; x.err = m_err;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; rv = 0; rpc = '0; rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== {RST_PC, 4'b0000}) begin
      n_bad++; $display("FAIL reset_hold: got %h want %h (pc,fv,fl,pd,er)", obs, {RST_PC, 4'b0000});
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (fv !== 1'b0) begin n_bad++; $display("FAIL boot_fv0: got %b want 0", fv); end
    for (int i = 0; i < BOOT; i++) begin
      drive(0, 0, '0, 1);
      e = sbq.pop_front(); n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL boot[%0d]: got %h want %h", i, obs, e); end
    end
    n_vec++;
    if (fv !== 1'b1 || pc !== RST_PC) begin
      n_bad++; $display("FAIL first_fetch: got fv=%b pc=%h want fv=1 pc=%h", fv, pc, RST_PC);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 1);
      e = sbq.pop_front(); n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL seq[%0d]: got %h want %h", i, obs, e); end
    end
    n_vec++;
    if (pc !== 32'h0040_000C) begin n_bad++; $display("FAIL seq_pc: got %h want 0040000c", pc); end
  endtask

  task automatic test_wait_stall();
    for (int i = 0; i < 6; i++) begin
      if (i < 3)      drive(0, 0, '0, 0);
      else if (i < 5) drive(1, 0, '0, 1);
      else            drive(0, 0, '0, 1);
      e = sbq.pop_front(); n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL wait_stall[%0d]: got %h want %h", i, obs, e); end
      if (i == 4) begin
        n_vec++;
        if (pc !== 32'h0040_000C || fv !== 1'b0) begin
          n_bad++; $display("FAIL stall_hold: got pc=%h fv=%b want pc=0040000c fv=0", pc, fv);
        end
      end
    end
  endtask

  task automatic test_redirect();
`ifdef FETCH_SEQ_DELAY_SLOT_EN
    drive(0, 1, 32'h0040_0200, 0);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ds_park: got %h want %h", obs, e); end
    n_vec++;
    if (pend !== 1'b1 || pc !== 32'h0040_0010) begin
      n_bad++; $display("FAIL ds_pending: got pend=%b pc=%h want pend=1 pc=00400010", pend, pc);
    end
    drive(0, 1, 32'h0040_0300, 0);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ds_second: got %h want %h", obs, e); end
    drive(0, 0, '0, 0);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ds_wait: got %h want %h", obs, e); end
    drive(0, 0, '0, 1);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ds_apply: got %h want %h", obs, e); end
    n_vec++;
    if (pc !== 32'h0040_0200 || flush !== 1'b0 || err !== 1'b1 || pend !== 1'b0) begin
      n_bad++; $display("FAIL ds_target: got pc=%h fl=%b er=%b pd=%b want 00400200 0 1 0", pc, flush, err, pend);
    end
    drive(0, 1, 32'h0040_0404, 1);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ds_immediate: got %h want %h", obs, e); end
    drive(1, 1, 32'h0040_0501, 1);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ds_stall_redir: got %h want %h", obs, e); end
    drive(0, 0, '0, 1);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ds_stall_apply: got %h want %h", obs, e); end
`else
    drive(1, 1, 32'h0040_0103, 0);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL nds_redir: got %h want %h", obs, e); end
    n_vec++;
    if (pc !== 32'h0040_0100 || flush !== 1'b1) begin
      n_bad++; $display("FAIL nds_target: got pc=%h fl=%b want 00400100 1", pc, flush);
    end
    drive(0, 0, '0, 1);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL nds_after: got %h want %h", obs, e); end
    n_vec++;
    if (flush !== 1'b0 || pc !== 32'h0040_0104) begin
      n_bad++; $display("FAIL nds_pulse: got pc=%h fl=%b want 00400104 0", pc, flush);
    end
    drive(0, 1, 32'h0040_0800, 1);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL nds_hs_redir: got %h want %h", obs, e); end
`endif
  endtask

  task automatic test_wrap();
    drive(0, 1, 32'hFFFF_FFFC, 1);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL wrap_set: got %h want %h", obs, e); end
    drive(0, 0, '0, 1);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL wrap_step: got %h want %h", obs, e); end
    n_vec++;
    if (pc !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(5) == 0), $urandom, ($urandom_range(3) != 0));
      e = sbq.pop_front(); n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL rand[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '0, 1);
      e = sbq.pop_front(); n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL ar_pre[%0d]: got %h want %h", i, obs, e); end
    end
    drive(0, 1, 32'h0040_0900, 0);
    e = sbq.pop_front(); n_vec++;
    if (obs !== e) begin n_bad++; $display("FAIL ar_redir: got %h want %h", obs, e); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== {RST_PC, 4'b0000}) begin
      n_bad++; $display("FAIL ar_async: got %h want %h", obs, {RST_PC, 4'b0000});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < BOOT + 1; i++) begin
      drive(0, 0, '0, 1);
      e = sbq.pop_front(); n_vec++;
      if (obs !== e) begin n_bad++; $display("FAIL ar_reboot[%0d]: got %h want %h", i, obs, e); end
    end
    n_vec++;
    if (pc !== 32'h0040_0004 || pend !== 1'b0) begin
      n_bad++; $display("FAIL ar_discard: got pc=%h pd=%b want 00400004 0", pc, pend);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_wait_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
